// File: rtl/uart_register_port.sv
// 8N1 UART peripheral on the hardware register bus: four-register window,
// TX/RX FIFOs, programmable baud divider, sticky overrun/framing flags.
module uart_register_port #(
  parameter logic [11:0] BASE_INDEX  = 12'h000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e   tx_state_q;
  rx_state_e   rx_state_q;
  logic [15:0] baud_q, tx_tmr_q, rx_tmr_q, rd_data_d, read_value_q;
  logic [2:0]  tx_bit_q, rx_bit_q;
  logic [7:0]  tx_sh_q, rx_sh_q;
  logic        tx_line_q, ovr_q, ferr_q;
  logic        rx_meta_q, rx_sync_q, rx_last_q;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [AW:0]   tx_cnt_q, rx_cnt_q;

  logic       sel, wr_status, wr_tx, wr_rx, wr_baud;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop, rx_stop_done, ovr_set, ferr_set;
  logic [7:0] tx_head, rx_head;

  assign sel       = (register_index[11:2] == BASE_INDEX[11:2]);
  assign wr_status = register_write && sel && (register_index[1:0] == 2'd0);
  assign wr_tx     = register_write && sel && (register_index[1:0] == 2'd1);
  assign wr_rx     = register_write && sel && (register_index[1:0] == 2'd2);
  assign wr_baud   = register_write && sel && (register_index[1:0] == 2'd3);

  assign tx_full  = (tx_cnt_q == DEPTH_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rd_ptr_q];
  assign rx_head  = rx_mem_q[rx_rd_ptr_q];

  // The transmitter takes a byte either from idle or at the end of a stop
  // bit, which is what keeps back-to-back frames gap-free.
  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                 ((tx_state_q == TX_STOP) && (tx_tmr_q == 16'd0)));

  assign rx_stop_done = (rx_state_q == RX_STOP) && (rx_tmr_q == 16'd0);
  assign rx_push      = rx_stop_done && rx_sync_q && !rx_full;
  assign ovr_set      = rx_stop_done && rx_sync_q && rx_full;
  assign ferr_set     = rx_stop_done && !rx_sync_q;
  assign rx_pop       = wr_rx && !rx_empty;

  assign uart_tx             = tx_line_q;
  assign rx_ready            = !rx_empty;
  assign register_read_value = read_value_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= register_write_value[7:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
      if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + (AW+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (AW+1)'(1);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
      if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + (AW+1)'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_line_q <= 1'b1;
          if (tx_pop) begin
            tx_sh_q    <= tx_head;
            tx_tmr_q   <= baud_q;
            tx_line_q  <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tmr_q == 16'd0) begin
            tx_tmr_q   <= baud_q;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_sh_q[0];
            tx_state_q <= TX_DATA;
          end else tx_tmr_q <= tx_tmr_q - 16'd1;
        end
        TX_DATA: begin
          if (tx_tmr_q == 16'd0) begin
            tx_tmr_q <= baud_q;
            if (tx_bit_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q  <= tx_bit_q + 3'd1;
              tx_sh_q   <= tx_sh_q >> 1;
              tx_line_q <= tx_sh_q[1];
            end
          end else tx_tmr_q <= tx_tmr_q - 16'd1;
        end
        TX_STOP: begin
          if (tx_tmr_q == 16'd0) begin
            if (tx_pop) begin
              tx_sh_q    <= tx_head;
              tx_tmr_q   <= baud_q;
              tx_line_q  <= 1'b0;
              tx_state_q <= TX_START;
            end else tx_state_q <= TX_IDLE;
          end else tx_tmr_q <= tx_tmr_q - 16'd1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // RX samples each bit near its centre; a low stop bit parks in RX_BREAK
  // until the line recovers so a held-low line cannot retrigger a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_last_q <= rx_sync_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_last_q && !rx_sync_q) begin
            rx_tmr_q   <= baud_q >> 1;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr_q == 16'd0) begin
            if (rx_sync_q) rx_state_q <= RX_IDLE;
            else begin
              rx_tmr_q   <= baud_q;
              rx_bit_q   <= '0;
              rx_state_q <= RX_DATA;
            end
          end else rx_tmr_q <= rx_tmr_q - 16'd1;
        end
        RX_DATA: begin
          if (rx_tmr_q == 16'd0) begin
            rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
            rx_tmr_q <= baud_q;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else rx_tmr_q <= rx_tmr_q - 16'd1;
        end
        RX_STOP: begin
          if (rx_tmr_q == 16'd0) rx_state_q <= rx_sync_q ? RX_IDLE : RX_BREAK;
          else rx_tmr_q <= rx_tmr_q - 16'd1;
        end
        RX_BREAK: if (rx_sync_q) rx_state_q <= RX_IDLE;
        default:  rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_d = 16'd0;
    if (register_read && sel) begin
      case (register_index[1:0])
        2'd0:    rd_data_d = {11'd0, ferr_q, ovr_q, tx_empty, tx_full, !rx_empty};
        2'd2:    rd_data_d = rx_empty ? 16'd0 : {8'd0, rx_head};
        2'd3:    rd_data_d = baud_q;
        default: rd_data_d = 16'd0;
      endcase
    end
  end

  // A flag raised in the same cycle as its clear write stays raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q       <= DEFAULT_DIV;
      ovr_q        <= 1'b0;
      ferr_q       <= 1'b0;
      read_value_q <= 16'd0;
    end else begin
      read_value_q <= rd_data_d;
      if (wr_baud) baud_q <= (register_write_value < 16'd3) ? 16'd3 : register_write_value;
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_status & register_write_value[3]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_status & register_write_value[4]));
    end
  end
endmodule

// File: tb/tb_uart_register_port.sv
// Directed-plus-random bench for uart_register_port: register map, serial
// TX/RX frames, FIFO limits, sticky flags and reset behaviour.
module tb_uart_register_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        uart_rx;
  logic        uart_tx;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: RX FIFO contents and sticky flags.
  logic [7:0] exp_q[$];
  bit         model_ovr;
  bit         model_ferr;

  uart_register_port dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_rx              (uart_rx),
    .uart_tx              (uart_tx),
    .rx_ready             (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input bit tx_full, input bit tx_empty);
    return {11'd0, model_ferr, model_ovr, tx_empty, tx_full, (exp_q.size() != 0)};
  endfunction

  task automatic model_rx(input logic [7:0] d);
    if (exp_q.size() < 8) exp_q.push_back(d);
    else model_ovr = 1'b1;
  endtask

  task automatic reg_read(input logic [11:0] idx, output logic [15:0] val);
    @(posedge clk); #1;
    register_index = idx;
    register_read  = 1'b1;
    @(posedge clk); #1;
    val = register_read_value;
    register_read = 1'b0;
  endtask

  task automatic reg_write(input logic [11:0] idx, input logic [15:0] val);
    @(posedge clk); #1;
    register_index       = idx;
    register_write_value = val;
    register_write       = 1'b1;
    @(posedge clk); #1;
    register_write = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop, input int n);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    @(posedge clk); #1;
    for (int b = 0; b < 10; b++) begin
      uart_rx = frame[b];
      repeat (n) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  // Decode one frame from uart_tx, sampling at bit centres of n clocks.
  task automatic tx_capture(input int n, output logic [7:0] d, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    d = 8'h00;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < 20 * n + 100) begin
      @(negedge clk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (n / 2) @(negedge clk);
    if (uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (n) @(negedge clk);
      d[i] = uart_tx;
    end
    repeat (n) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    logic [15:0] rv;
    logic [7:0]  got, d;
    logic [7:0]  burst [10];
    logic [9:0]  frame;
    bit          ok;
    int          lows, nd, waited;

    reset = 1'b1;
    register_index = 12'h000;
    register_read = 1'b0;
    register_write = 1'b0;
    register_write_value = 16'h0000;
    uart_rx = 1'b1;
    model_ovr = 1'b0;
    model_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_uart_tx", uart_tx, 1);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_read_value", register_read_value, 0);
    reset = 1'b0;

    // Read latency: data appears exactly one edge after the strobe.
    @(posedge clk); #1;
    register_index = 12'h000;
    register_read = 1'b1;
    chk("read_before_edge", register_read_value, 0);
    @(posedge clk); #1;
    chk("status_reset", register_read_value, 16'h0004);
    register_read = 1'b0;
    @(posedge clk); #1;
    chk("read_after_strobe", register_read_value, 0);
    reg_read(12'h001, rv); chk("tx_data_read", rv, 0);
    reg_read(12'h002, rv); chk("rx_data_empty", rv, 0);
    reg_read(12'h003, rv); chk("baud_reset", rv, 16'd433);

    // Burst of 10 at default divider: 9 accepted, 10th dropped.
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      register_index = 12'h001;
      register_write_value = {8'h00, burst[i]};
      register_write = 1'b1;
    end
    @(posedge clk); #1;
    register_write = 1'b0;
    reg_read(12'h000, rv); chk("status_tx_full", rv, exp_status(1, 0));
    for (int k = 0; k < 9; k++) begin
      tx_capture(434, got, ok);
      chk("burst_frame_ok", ok, 1);
      chk("burst_frame_data", got, burst[k]);
    end
    lows = 0;
    repeat (5500) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("no_tenth_frame", lows, 0);
    reg_read(12'h000, rv); chk("status_tx_drained", rv, exp_status(0, 1));

    // Divider clamp, then exact waveform of 0xA5 at 4 clocks per bit.
    reg_write(12'h003, 16'($urandom_range(0, 2)));
    reg_read(12'h003, rv); chk("baud_clamp", rv, 16'd3);
    reg_write(12'h001, 16'h00A5);
    waited = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("a5_start_seen", uart_tx, 0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) begin
      chk("a5_wave", uart_tx, frame[j / 4]);
      @(negedge clk);
    end
    reg_read(12'h000, rv); chk("a5_status_empty", rv, exp_status(0, 1));

    // Random TX bytes at random dividers.
    for (int k = 0; k < 4; k++) begin
      nd = $urandom_range(3, 12);
      d = 8'($urandom_range(0, 255));
      reg_write(12'h003, 16'(nd));
      reg_write(12'h001, {8'h00, d});
      tx_capture(nd + 1, got, ok);
      chk("rand_tx_ok", ok, 1);
      chk("rand_tx_data", got, d);
      repeat (nd + 2) @(posedge clk);
    end
    reg_read(12'h000, rv); chk("rand_tx_status", rv, exp_status(0, 1));

    // Receive 0x3C at divider 3, then pop it.
    reg_write(12'h003, 16'd3);
    rx_send(8'h3C, 1'b1, 4);
    model_rx(8'h3C);
    repeat (4) @(posedge clk);
    #1;
    chk("rx_ready_set", rx_ready, 1);
    reg_read(12'h002, rv); chk("rx_data_3c", rv, 16'h003C);
    reg_read(12'h000, rv); chk("rx_status", rv, exp_status(0, 1));
    reg_write(12'h002, 16'h0000);
    void'(exp_q.pop_front());
    chk("rx_ready_clear", rx_ready, 0);

    // Random RX bytes at random dividers.
    for (int k = 0; k < 4; k++) begin
      nd = $urandom_range(3, 12);
      d = 8'($urandom_range(0, 255));
      reg_write(12'h003, 16'(nd));
      rx_send(d, 1'b1, nd + 1);
      model_rx(d);
      repeat (4) @(posedge clk);
      #1;
      chk("rand_rx_ready", rx_ready, 1);
      reg_read(12'h002, rv); chk("rand_rx_data", rv, {8'h00, exp_q[0]});
      reg_write(12'h002, 16'h0000);
      void'(exp_q.pop_front());
    end

    // Nine frames without popping: eight stored, overrun raised.
    reg_write(12'h003, 16'd3);
    for (int k = 0; k < 9; k++) begin
      d = 8'($urandom_range(0, 255));
      rx_send(d, 1'b1, 4);
      model_rx(d);
    end
    repeat (4) @(posedge clk);
    reg_read(12'h000, rv); chk("overrun_status", rv, exp_status(0, 1));
    while (exp_q.size() != 0) begin
      reg_read(12'h002, rv); chk("overrun_fifo_data", rv, {8'h00, exp_q[0]});
      reg_write(12'h002, 16'h0000);
      void'(exp_q.pop_front());
    end
    reg_read(12'h000, rv); chk("overrun_after_pop", rv, exp_status(0, 1));
    reg_write(12'h000, 16'h0008);
    model_ovr = 1'b0;
    reg_read(12'h000, rv); chk("overrun_cleared", rv, exp_status(0, 1));

    // Low stop bit: nothing stored, framing error raised then cleared.
    rx_send(8'h55, 1'b0, 4);
    model_ferr = 1'b1;
    repeat (6) @(posedge clk);
    reg_read(12'h000, rv); chk("frame_err_status", rv, exp_status(0, 1));
    reg_write(12'h000, 16'h0010);
    model_ferr = 1'b0;
    reg_read(12'h000, rv); chk("frame_err_cleared", rv, exp_status(0, 1));

    // One-clock glitch in idle leaves no byte and no flag.
    @(posedge clk); #1;
    uart_rx = 1'b0;
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_rx_ready", rx_ready, 0);
    reg_read(12'h000, rv); chk("glitch_status", rv, exp_status(0, 1));

    // Indices outside the window read as zero.
    reg_read(12'h004, rv); chk("unselected_004", rv, 0);
    reg_read(12'h007, rv); chk("unselected_007", rv, 0);

    // Reset in the middle of a frame forces the line high at once.
    reg_write(12'h003, 16'd20);
    reg_write(12'h001, 16'h0000);
    repeat (30) @(posedge clk);
    #1;
    chk("midframe_tx_low", uart_tx, 0);
    reset = 1'b1;
    #1;
    chk("midframe_reset_tx", uart_tx, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_ovr = 1'b0;
    model_ferr = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post_reset_idle", lows, 0);
    reg_read(12'h003, rv); chk("post_reset_baud", rv, 16'd433);
    reg_read(12'h000, rv); chk("post_reset_status", rv, exp_status(0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_register_port.md
Name: uart_register_port

Overview:
- Memory-mapped 8N1 UART peripheral on the Lisp core's hardware register bus. Register space is data addresses 0xF000-0xFFFF; the bus carries a 12-bit index.
- Decodes a 4-register window and buffers traffic in TX and RX FIFOs.
- Returns read data one cycle after the read strobe, which is when the top level samples register_read_value.
- Read data is zero when this block is not selected, so several peripherals can be OR-combined onto register_read_value.

Parameters:
- BASE_INDEX, 12'h000: window base. Only [11:2] are compared; [1:0] are ignored.
- FIFO_DEPTH, 8: entries per FIFO. Must be a power of two, 2 or more.
- DEFAULT_DIV, 16'd433: reset value of BAUD_DIV (clocks per bit minus 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- register_index  in  12  register index from the core
- register_read  in  1  read strobe; may stay high for several cycles
- register_write  in  1  write strobe, one cycle per write
- register_write_value  in  16  write data
- register_read_value  out  16  registered read data
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, idle high
- rx_ready  out  1  high while the RX FIFO is non-empty

Behaviour:
- Reset state:
  - register_read_value = 0, uart_tx = 1, rx_ready = 0.
  - Both FIFOs empty, sticky flags clear, BAUD_DIV = DEFAULT_DIV, TX and RX FSMs in IDLE.
  - Reset asserted mid-frame aborts the frame immediately; uart_tx returns high.
- Selection: sel = (register_index[11:2] == BASE_INDEX[11:2]). Offset = register_index[1:0].
- Read path: every posedge, register_read_value <= (register_read && sel) ? reg[offset] : 0. Latency is 1 cycle. Reads have no side effects.
- Register map:
  - Offset 0, STATUS.
    - Read bits: [0] rx_not_empty, [1] tx_full, [2] tx_empty, [3] rx_overrun, [4] rx_frame_err; [15:5] = 0.
    - Write: a 1 in bit 3 or bit 4 clears that sticky flag.
  - Offset 1, TX_DATA.
    - Write pushes value[7:0]. The push is silently dropped if the TX FIFO is full.
    - Reads return 0.
  - Offset 2, RX_DATA.
    - Read returns the FIFO head zero-extended, or 0 if empty.
    - Any write pops one entry; ignored if empty.
  - Offset 3, BAUD_DIV.
    - Read/write, 16 bits.
    - Written values below 3 are stored as 3.
    - A new value applies from the next bit boundary of any frame in flight.
- FIFO rules (both FIFOs):
  - Full and empty are evaluated on the pre-edge count.
  - A push while full is dropped even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- TX FSM:
  - States: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, pop the head and enter START.
  - Each bit lasts BAUD_DIV+1 clocks, using a counter reloaded at every bit start.
  - Back-to-back bytes produce no idle gap.
  - uart_tx is a registered output.
- RX FSM:
  - uart_rx passes through a 2-flop synchronizer, initialised to 1.
  - States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge starts the half-bit counter, BAUD_DIV>>1.
  - START: at mid-bit, if the line is high it is a glitch; return to IDLE with nothing recorded. Otherwise sample 8 data bits at bit centres (every BAUD_DIV+1 clocks), then the stop bit.
  - Stop bit = 1: push the byte. If the FIFO is full, drop it and set rx_overrun.
  - Stop bit = 0: discard the byte, set rx_frame_err, and wait for the line to go high before returning to IDLE.
- A sticky flag being set in the same cycle as a clear write takes priority: the flag stays set.

Test Plan:
- Reset, then read offsets 0-3 with BASE_INDEX=0 -> STATUS 0x0004, TX/RX_DATA 0, BAUD_DIV 433. Read data appears exactly one cycle after the strobe. uart_tx=1.
- BAUD_DIV=3, write TX_DATA 0xA5 -> uart_tx is low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4. STATUS bit2 returns to 1.
- BAUD_DIV=3, drive 0x3C serially on uart_rx -> rx_ready=1 and RX_DATA reads 0x003C. A write to offset 2 pops it and rx_ready=0.
- FIFO_DEPTH=8: write 10 bytes with BAUD_DIV=433 -> the TX FIFO accepts 9 (one popped immediately into the shifter) and STATUS bit1=1. Exactly 9 frames appear on uart_tx.
- Receive 9 frames without popping -> 8 entries stored and STATUS bit3=1. Writing 0x0008 to STATUS clears bit3.
- Frame with a low stop bit -> nothing pushed, bit4=1. A 1-clock low glitch in IDLE -> no byte and no flag. A read with register_index=0x004 -> read value 0 (not selected).
